// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding, default width and counter sizing for serial_adder
package serial_adder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational 1-bit full adder
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder cell plus a carry flip-flop, LSB first
//   clk, rst          : clock, synchronous active-high reset
//   start, a, b, cin  : operands captured when start is seen in IDLE or DONE
//   sum, cout, ovf    : result, held from the done cycle until the next result
//   busy, done        : busy high in RUN, done a one-cycle result-valid pulse
//   SERIAL_ADDER_OVF_EN defined: ovf reports signed overflow; otherwise ovf is tied low
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  localparam int CW = cnt_w(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, s_next;
  logic [WIDTH-2:0] s_sh;
  logic [CW-1:0]    cnt;
  logic             carry, s, co, last;
  fa_cell u_fa (.a(a_sh[0]), .b(b_sh[0]), .ci(carry), .s(s), .co(co));
  // new bit enters at the top; after the last step s_next holds the whole sum
  assign s_next = {s, s_sh};
  assign last   = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= s_next[WIDTH-1:1];
      carry <= co;
      cnt   <= last ? cnt : cnt + 1'b1;
      state <= last ? DONE : RUN;
      busy  <= !last;
      done  <= last;
      if (last) begin
        sum  <= s_next;
        cout <= co;
      end
    end else begin
      if (start) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
        s_sh  <= '0;
      end
      state <= start ? RUN : IDLE;
      busy  <= start;
      done  <= 1'b0;
    end
  end
`ifdef SERIAL_ADDER_OVF_EN
  // carry into the MSB differs from carry out of it exactly on signed overflow
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (state == RUN && last) ovf <= carry ^ co;
  end
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed scoreboard bench for serial_adder
module tb_serial_adder;
  localparam int W = 8;
  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum;
  logic         cout, ovf, busy, done;
  int           checks = 0;
  int           errors = 0;
  exp_t         q[$];
  int           n, bc, hits;
  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t        e;
    logic [W:0]  full;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s = full[W-1:0];
    e.c = full[W];
`ifdef SERIAL_ADDER_OVF_EN
    e.o = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
`else
    e.o = 1'b0;
`endif
    q.push_back(e);
  endtask
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    a = x;
    b = y;
    cin = ci;
    start = 1'b1;
    push(x, y, ci);
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input string tag, output int cyc, output int bcnt);
    exp_t e;
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < 40) begin
      bcnt += int'(busy);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    if (done) begin
      if (q.size() == 0) chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk({tag, " sum"}, {24'd0, sum}, {24'd0, e.s});
        chk({tag, " cout"}, {31'd0, cout}, {31'd0, e.c});
        chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, e.o});
      end
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset sum", {24'd0, sum}, 32'd0);
    chk("reset flags", {28'd0, cout, ovf, busy, done}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    start_op(8'h0F, 8'h01, 1'b0);
    wait_done("basic", n, bc);
    chk("basic latency", n, W);
    chk("basic busy cycles", bc, W);
    chk("basic sum value", {24'd0, sum}, 32'h10);
    @(posedge clk);
    #1;
    chk("done single pulse", {30'd0, done, busy}, 32'd0);
    chk("sum held", {23'd0, cout, sum}, 32'h10);
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done("wrap", n, bc);
    chk("wrap result", {23'd0, cout, sum}, 32'h100);
    @(posedge clk);
    #1;
    start_op(8'h00, 8'h00, 1'b1);
    wait_done("cin only", n, bc);
    @(posedge clk);
    #1;
    start_op(8'h7F, 8'h01, 1'b0);
    wait_done("ovf pos", n, bc);
    @(posedge clk);
    #1;
    start_op(8'h80, 8'h80, 1'b0);
    wait_done("ovf neg", n, bc);
    @(posedge clk);
    #1;
    start_op(8'h12, 8'h34, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    a = 8'hAA;
    b = 8'h55;
    cin = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("start ignored", n, bc);
    chk("start ignored sum", {24'd0, sum}, 32'h47);
    @(posedge clk);
    #1;
    start_op(8'h01, 8'h02, 1'b0);
    wait_done("b2b first", n, bc);
    start_op(8'h22, 8'h11, 1'b0);
    chk("b2b no idle", {30'd0, busy, done}, 32'd2);
    wait_done("b2b second", n, bc);
    chk("b2b latency", n, W);
    chk("b2b sum value", {24'd0, sum}, 32'h33);
    @(posedge clk);
    #1;
    start_op(8'hC3, 8'h5A, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("busy before abort", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    chk("abort state", {23'd0, cout, sum}, 32'd0);
    chk("abort flags", {29'd0, ovf, busy, done}, 32'd0);
    hits = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      hits += int'(done) + int'(busy);
    end
    chk("no done after abort", hits, 0);
    rst = 1'b1;
    start = 1'b1;
    a = 8'h01;
    b = 8'h01;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    chk("rst beats start", {31'd0, busy}, 32'd0);
    start_op(8'h3C, 8'h44, 1'b0);
    wait_done("after abort", n, bc);
    chk("after abort latency", n, W);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      start_op(W'($urandom), W'($urandom), 1'($urandom));
      wait_done("random", n, bc);
    end
    chk("scoreboard drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
